fanout_tree_bank: RTL and testbench



---
 rtl/fanout_tree_pkg.sv | 52 +++++
 rtl/fanout_tree_level.sv | 33 +++
 rtl/fanout_tree_bank.sv | 132 +++++++++++++
 tb/tb_fanout_tree_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fanout_tree_pkg.sv
// rtl/fanout_tree_pkg.sv - sizing helpers and parity helper for the fanout tree bank
// Purpose: tree geometry functions (level count, nodes per level, bus offsets)
//          and an even-parity helper shared by the tree files.
// Macro:   FANOUT_TREE_PARITY_EN adds one parity bit per tree node.
package fanout_tree_pkg;

  // Widest value the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 1024;

`ifdef FANOUT_TREE_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Smallest L >= 1 with branch**L >= num_loads.
  function automatic int calc_levels(input int num_loads, input int branch);
    int     l;
    longint p;
    l = 1;
    p = longint'(branch);
    while (p < longint'(num_loads)) begin
      p = p * longint'(branch);
      l = l + 1;
    end
    return l;
  endfunction

  // Nodes at level k: ceil(num_loads / branch**(levels-k)).
  function automatic int calc_nodes(input int num_loads, input int branch,
                                    input int levels, input int k);
    longint p;
    p = 1;
    for (int i = 0; i < levels - k; i++) p = p * longint'(branch);
    return int'((longint'(num_loads) + p - 1) / p);
  endfunction

  // Node index where level k starts inside the flattened tree bus.
  function automatic int calc_offset(input int num_loads, input int branch,
                                     input int levels, input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s = s + calc_nodes(num_loads, branch, levels, i);
    return s;
  endfunction

  // Even parity: returns the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fanout_tree_level.sv
// rtl/fanout_tree_level.sv - one registered level of the fanout tree
// Purpose: NK enable-gated node registers; node j copies parent node j/BRANCH.
// Ports:   clk1, rst_n (async active-low), en (advance),
//          parent (NP nodes of DW bits), flip (per-node bit-0 invert),
//          q (NK nodes of DW bits).
module fanout_tree_level
  import fanout_tree_pkg::*;
#(
  parameter int DW     = 1,
  parameter int NP     = 1,
  parameter int NK     = 4,
  parameter int BRANCH = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NP*DW-1:0]  parent,
  input  logic [NK-1:0]     flip,
  output logic [NK*DW-1:0]  q
);

  // flip only touches bit 0 (a data bit); parity, when present, sits at the MSB.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      for (int j = 0; j < NK; j++) begin
        q[j*DW +: DW] <= parent[(j/BRANCH)*DW +: DW] ^ DW'(flip[j]);
      end
    end
  end

endmodule

// File: rtl/fanout_tree_bank.sv
// rtl/fanout_tree_bank.sv - source register fanned out through a registered tree to NUM_LOADS leaves
// Purpose: drvr register -> LEVELS tree levels -> leaf registers, a valid pipe
//          alongside, and a leaf-consistency checker with a saturating counter.
// Ports:   clk1, rst_n (async active-low), en (global advance), in_valid, in,
//          inj / inj_idx (leaf fault injection), err_clr (sync clear),
//          out_valid, load_q (leaf i at [i*WIDTH +: WIDTH]), mismatch, err_cnt.
// Macro:   FANOUT_TREE_PARITY_EN carries an even-parity bit per node and checks it at the leaves.
module fanout_tree_bank
  import fanout_tree_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int NUM_LOADS = 35,
  parameter int BRANCH    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in,
  input  logic                          inj,
  input  logic [$clog2(NUM_LOADS)-1:0]  inj_idx,
  input  logic                          err_clr,
  output logic                          out_valid,
  output logic [NUM_LOADS*WIDTH-1:0]    load_q,
  output logic                          mismatch,
  output logic [CNT_W-1:0]              err_cnt
);

  localparam int LEVELS = calc_levels(NUM_LOADS, BRANCH);
  localparam int DW     = WIDTH + PAR_BITS;
  localparam int IW     = $clog2(NUM_LOADS);
  localparam int TOTAL  = calc_offset(NUM_LOADS, BRANCH, LEVELS, LEVELS + 1);
  localparam int LEAF0  = calc_offset(NUM_LOADS, BRANCH, LEVELS, LEVELS);

  // All levels packed back to back, level 0 (drvr) at the bottom.
  wire  [TOTAL*DW-1:0]     tree;
  logic [DW-1:0]           drvr;
  logic [DW-1:0]           drvr_d;
  logic [NUM_LOADS-1:0]    leaf_flip;
  logic [NUM_LOADS-1:0]    diff;
  logic [LEVELS:0]         vpipe;
  logic                    bad;

`ifdef FANOUT_TREE_PARITY_EN
  logic [NUM_LOADS-1:0]    perr;
  assign drvr_d = {even_parity(PAR_MAX_W'(in)), in};
`else
  assign drvr_d = in;
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      drvr <= '0;
    end else if (en) begin
      drvr <= drvr_d;
    end
  end

  assign tree[DW-1:0] = drvr;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NK  = calc_nodes(NUM_LOADS, BRANCH, LEVELS, k);
    localparam int NP  = calc_nodes(NUM_LOADS, BRANCH, LEVELS, k - 1);
    localparam int OK  = calc_offset(NUM_LOADS, BRANCH, LEVELS, k);
    localparam int OP  = calc_offset(NUM_LOADS, BRANCH, LEVELS, k - 1);
    logic [NK-1:0] flip;

    // Only the leaf level can be corrupted.
    if (k == LEVELS) begin : g_leaf
      assign flip = leaf_flip;
    end else begin : g_inner
      assign flip = '0;
    end

    fanout_tree_level #(
      .DW     (DW),
      .NP     (NP),
      .NK     (NK),
      .BRANCH (BRANCH)
    ) u_level (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .en     (en),
      .parent (tree[OP*DW +: NP*DW]),
      .flip   (flip),
      .q      (tree[OK*DW +: NK*DW])
    );
  end

  // Leaf decode; an index at or beyond NUM_LOADS matches no leaf.
  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_leafchk
    assign leaf_flip[i] = inj && (inj_idx == IW'(i));
    assign load_q[i*WIDTH +: WIDTH] = tree[(LEAF0+i)*DW +: WIDTH];
    assign diff[i] = (tree[(LEAF0+i)*DW +: WIDTH] != tree[LEAF0*DW +: WIDTH]);
`ifdef FANOUT_TREE_PARITY_EN
    assign perr[i] = even_parity(PAR_MAX_W'(tree[(LEAF0+i)*DW +: DW]));
`endif
  end

`ifdef FANOUT_TREE_PARITY_EN
  assign bad = (|diff) | (|perr);
`else
  assign bad = |diff;
`endif

  // Valid rides its own pipe, one bit per stage, never fanned out.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else if (en) begin
      vpipe <= {vpipe[LEVELS-1:0], in_valid};
    end
  end

  assign out_valid = vpipe[LEVELS];

  // Checker looks at the leaves as they stand; clear beats a same-edge increment.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (en && out_valid && bad) begin
      mismatch <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fanout_tree_bank.sv
// tb/tb_fanout_tree_bank.sv - directed self-checking bench for fanout_tree_bank
module tb_fanout_tree_bank;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [0:0]  in;
  logic        inj;
  logic [5:0]  inj_idx;
  logic        err_clr;
  logic [7:0]  in_w;
  logic [5:0]  inj_idx_w;

  logic        out_valid, mismatch;
  logic [34:0] load_q;
  logic [15:0] err_cnt;

  logic        out_valid_s, mismatch_s;
  logic [34:0] load_q_s;
  logic [1:0]  err_cnt_s;

  logic         out_valid_w, mismatch_w;
  logic [511:0] load_q_w;
  logic [15:0]  err_cnt_w;

  int checks   = 0;
  int failures = 0;

  localparam logic [34:0]  ALL1  = {35{1'b1}};
  localparam logic [511:0] ALLA5 = {64{8'hA5}};

  logic dp[4];

  always #5 clk1 = ~clk1;

  fanout_tree_bank dut (
    .clk1(clk1), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in),
    .inj(inj), .inj_idx(inj_idx), .err_clr(err_clr),
    .out_valid(out_valid), .load_q(load_q), .mismatch(mismatch), .err_cnt(err_cnt)
  );

  fanout_tree_bank #(.CNT_W(2)) dut_s (
    .clk1(clk1), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in),
    .inj(inj), .inj_idx(inj_idx), .err_clr(err_clr),
    .out_valid(out_valid_s), .load_q(load_q_s), .mismatch(mismatch_s), .err_cnt(err_cnt_s)
  );

  fanout_tree_bank #(.WIDTH(8), .NUM_LOADS(64), .BRANCH(2)) dut_w (
    .clk1(clk1), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in_w),
    .inj(inj), .inj_idx(inj_idx_w), .err_clr(err_clr),
    .out_valid(out_valid_w), .load_q(load_q_w), .mismatch(mismatch_w), .err_cnt(err_cnt_w)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in = 1'b0; inj = 1'b0;
    inj_idx = 6'd0; err_clr = 1'b0; in_w = 8'h00; inj_idx_w = 6'd63;
    tick(); tick();
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_load_q",    512'(load_q),    512'(0));
    chk("rst_mismatch",  512'(mismatch),  512'(0));
    chk("rst_err_cnt",   512'(err_cnt),   512'(0));
    chk("rst_s_all",     512'({out_valid_s, mismatch_s, err_cnt_s, load_q_s}), 512'(0));
    chk("rst_w_load_q",  load_q_w, 512'(0));
    chk("rst_w_flags",   512'({out_valid_w, mismatch_w, err_cnt_w}), 512'(0));
    rst_n = 1'b1;

    // latency: captured at e0, visible after e3 (narrow) / e6 (wide)
    in = 1'b1; in_valid = 1'b1; in_w = 8'hA5;
    tick(); tick(); tick();
    chk("lat_valid_early", 512'(out_valid), 512'(0));
    chk("lat_load_early",  512'(load_q),    512'(0));
    tick();
    chk("lat_load_q",    512'(load_q),    512'(ALL1));
    chk("lat_valid",     512'(out_valid), 512'(1));
    chk("lat_mismatch",  512'(mismatch),  512'(0));
    chk("lat_err_cnt",   512'(err_cnt),   512'(0));
    tick();
    tick();
    chk("w_valid_early", 512'(out_valid_w), 512'(0));
    tick();
    chk("w_load_q",      load_q_w, ALLA5);
    chk("w_valid",       512'(out_valid_w), 512'(1));
    chk("ok_mismatch",   512'(mismatch), 512'(0));

    // toggle with a 2-cycle en=0 hole
    for (int i = 0; i < 4; i++) dp[i] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      en = (i == 4 || i == 5) ? 1'b0 : 1'b1;
      in = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (en) begin
        dp[3] = dp[2]; dp[2] = dp[1]; dp[1] = dp[0]; dp[0] = in[0];
      end
      chk($sformatf("tog_load_%0d", i), 512'(load_q), 512'({35{dp[3]}}));
    end
    en = 1'b1; in = 1'b1;
    tick(); tick(); tick(); tick();
    chk("tog_flush",    512'(load_q),   512'(ALL1));
    chk("tog_mismatch", 512'(mismatch), 512'(0));
    chk("tog_err_cnt",  512'(err_cnt),  512'(0));

    // single injection on leaf 17 (and leaf 63 of the wide tree)
    inj = 1'b1; inj_idx = 6'd17; inj_idx_w = 6'd63;
    tick();
    chk("inj_load_q",   512'(load_q), 512'(ALL1 & ~(35'd1 << 17)));
    chk("inj_valid",    512'(out_valid), 512'(1));
    chk("inj_mm_early", 512'(mismatch), 512'(0));
    chk("inj_w_leaf63", 512'(load_q_w[511:504]), 512'(8'hA4));
    inj = 1'b0;
    tick();
    chk("inj_mismatch", 512'(mismatch), 512'(1));
    chk("inj_err_cnt",  512'(err_cnt),  512'(1));
    chk("inj_s_cnt",    512'(err_cnt_s), 512'(1));
    chk("inj_w_mm",     512'(mismatch_w), 512'(1));
    chk("inj_restored", 512'(load_q), 512'(ALL1));
    tick();
    chk("inj_cnt_hold", 512'(err_cnt), 512'(1));

    // continuous injection, saturation, clear priority
    inj = 1'b1;
    tick();
    chk("cont_cnt1", 512'(err_cnt), 512'(1));
    tick(); tick(); tick(); tick();
    chk("cont_cnt5",  512'(err_cnt),   512'(5));
    chk("sat_cnt3",   512'(err_cnt_s), 512'(3));
    chk("sat_mm",     512'(mismatch_s), 512'(1));
    err_clr = 1'b1;
    tick();
    chk("clr_cnt",    512'(err_cnt),   512'(0));
    chk("clr_s_cnt",  512'(err_cnt_s), 512'(0));
    chk("clr_mm",     512'(mismatch),  512'(0));
    err_clr = 1'b0; inj = 1'b0;
    tick();
    chk("post_clr_cnt", 512'(err_cnt), 512'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // out-of-range index is ignored
    inj = 1'b1; inj_idx = 6'd40;
    tick(); tick(); tick();
    chk("oor_load_q",   512'(load_q),   512'(ALL1));
    chk("oor_mismatch", 512'(mismatch), 512'(0));
    chk("oor_err_cnt",  512'(err_cnt),  512'(0));
    inj = 1'b0;

    // invalid data still flows but is not checked
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("inv_valid",  512'(out_valid), 512'(0));
    chk("inv_load_q", 512'(load_q),    512'(ALL1));
    inj = 1'b1; inj_idx = 6'd3;
    tick();
    chk("inv_inj_load", 512'(load_q), 512'(ALL1 & ~(35'd1 << 3)));
    inj = 1'b0;
    tick();
    chk("inv_mismatch", 512'(mismatch), 512'(0));
    chk("inv_err_cnt",  512'(err_cnt),  512'(0));

    // asynchronous reset mid-stream
    in_valid = 1'b1;
    tick(); tick(); tick(); tick();
    inj = 1'b1; inj_idx = 6'd0;
    tick();
    inj = 1'b0;
    tick();
    chk("pre_rst_mm", 512'(mismatch), 512'(1));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load_q", 512'(load_q),    512'(0));
    chk("arst_valid",  512'(out_valid), 512'(0));
    chk("arst_mm",     512'(mismatch),  512'(0));
    chk("arst_cnt",    512'(err_cnt),   512'(0));
    chk("arst_w",      load_q_w,        512'(0));
    chk("arst_w_flags", 512'({out_valid_w, mismatch_w, err_cnt_w}), 512'(0));
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("post_rst_valid", 512'(out_valid), 512'(0));
    chk("post_rst_mm",    512'(mismatch),  512'(0));
    chk("post_rst_cnt",   512'(err_cnt),   512'(0));
    chk("post_rst_load",  512'(load_q),    512'(ALL1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
